// File: rtl/aclint_multi_hart_if.sv
// aclint_multi_hart_if
//   Memory-bus slave port of the ACLINT.
//   Request:  valid, addr[63:0], wen, wdata[63:0], wmask[7:0]  (master -> slave)
//   Response: ready (tied high), rvalid, rdata[63:0]           (slave -> master)
interface aclint_multi_hart_if;
  logic        valid;
  logic        ready;
  logic [63:0] addr;
  logic        wen;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic        rvalid;
  logic [63:0] rdata;

  modport master (output valid, addr, wen, wdata, wmask, input ready, rvalid, rdata);
  modport slave  (input valid, addr, wen, wdata, wmask, output ready, rvalid, rdata);
endinterface

// File: rtl/aclint_multi_hart.sv
// aclint_multi_hart
//   ACLINT MSWI + MTIMER for up to 8 harts behind one bus slave port.
//   Ports:
//     clk, rst       - clock, synchronous active-high reset
//     membus         - aclint_multi_hart_if.slave request/response port
//     msip[HART_NUM] - per-hart software interrupt pending
//     mtip[HART_NUM] - per-hart timer interrupt pending (registered compare)
//     mtime[63:0]    - current MTIME
//   Map (64-bit words, addr[2:0] ignored):
//     0x0000+8k : MSIP[2k] bit 0, MSIP[2k+1] bit 32
//     0x4000+8h : MTIMECMP[h]
//     0xBFF8    : MTIME
//   Build option: ACLINT_PRESCALE_EN enables a TICK_DIV-cycle prescaler
//   for MTIME; otherwise MTIME increments every cycle.

// Per-hart MTIMECMP register and timer-interrupt flop.
module aclint_hart_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [63:0] wdata_i,
  input  logic [7:0]  wmask_i,
  input  logic [63:0] mtime_i,
  output logic [63:0] cmp_o,
  output logic        mtip_o
);
  logic [63:0] cmp_q, cmp_d;
  logic        mtip_q;

  always_comb begin
    cmp_d = cmp_q;
    for (int b = 0; b < 8; b++)
      if (we_i && wmask_i[b]) cmp_d[8*b +: 8] = wdata_i[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_q  <= '1;
      mtip_q <= 1'b0;
    end else begin
      cmp_q  <= cmp_d;
      mtip_q <= (mtime_i >= cmp_q);
    end
  end

  assign cmp_o  = cmp_q;
  assign mtip_o = mtip_q;
endmodule

module aclint_multi_hart #(
  parameter int unsigned HART_NUM = 1,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic                clk,
  input  logic                rst,
  aclint_multi_hart_if.slave  membus,
  output logic [HART_NUM-1:0] msip,
  output logic [HART_NUM-1:0] mtip,
  output logic [63:0]         mtime
);
  logic [12:0] widx;
  logic        wr, rd, sel_msip, sel_cmp, sel_mtime, tick;
  logic [63:0] mtime_q, mtime_d, mtime_inc;
  logic [63:0] rdata_q, rdata_d;
  logic        rvalid_q;
  logic [HART_NUM-1:0]        msip_q, msip_d, cmp_we;
  logic [HART_NUM-1:0][63:0]  cmp;

  assign widx      = membus.addr[15:3];
  assign wr        = membus.valid &&  membus.wen;
  assign rd        = membus.valid && !membus.wen;
  assign sel_msip  = (widx[12:11] == 2'b00);
  assign sel_cmp   = (widx[12:11] == 2'b01);
  assign sel_mtime = (widx == 13'h17FF);

  logic unused_addr;
  assign unused_addr = ^{membus.addr[63:16], membus.addr[2:0]};

`ifdef ACLINT_PRESCALE_EN
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] presc_q;
  // Free-running; MTIME writes deliberately leave the phase untouched.
  assign tick = (presc_q == PW'(TICK_DIV - 1));
  always_ff @(posedge clk) begin
    if (rst)       presc_q <= '0;
    else if (tick) presc_q <= '0;
    else           presc_q <= presc_q + 1'b1;
  end
`else
  logic [31:0] unused_tick_div;
  assign unused_tick_div = 32'(TICK_DIV);
  assign tick = 1'b1;
`endif

  // Written bytes override the increment; the rest take the incremented value.
  assign mtime_inc = mtime_q + {63'd0, tick};
  always_comb begin
    mtime_d = mtime_inc;
    for (int b = 0; b < 8; b++)
      if (wr && sel_mtime && membus.wmask[b]) mtime_d[8*b +: 8] = membus.wdata[8*b +: 8];
  end

  for (genvar h = 0; h < HART_NUM; h++) begin : g_hart
    localparam int unsigned LANE = h % 2;
    logic msip_we;
    // Even harts live in lane 0 / bit 0, odd harts in lane 4 / bit 32.
    assign msip_we   = wr && sel_msip && (widx[10:0] == 11'(h / 2)) && membus.wmask[4*LANE];
    assign msip_d[h] = msip_we ? membus.wdata[32*LANE] : msip_q[h];
    assign cmp_we[h] = wr && sel_cmp && (widx[10:0] == 11'(h));

    aclint_hart_timer u_timer (
      .clk     (clk),
      .rst     (rst),
      .we_i    (cmp_we[h]),
      .wdata_i (membus.wdata),
      .wmask_i (membus.wmask),
      .mtime_i (mtime_q),
      .cmp_o   (cmp[h]),
      .mtip_o  (mtip[h])
    );
  end

  // Read data reflects register values before this cycle's update.
  always_comb begin
    rdata_d = '0;
    if (rd) begin
      if (sel_msip) begin
        for (int h = 0; h < int'(HART_NUM); h++)
          if (widx[10:0] == 11'(h / 2)) rdata_d[32*(h%2)] = msip_q[h];
      end else if (sel_cmp) begin
        for (int h = 0; h < int'(HART_NUM); h++)
          if (widx[10:0] == 11'(h)) rdata_d = cmp[h];
      end else if (sel_mtime) begin
        rdata_d = mtime_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q  <= '0;
      msip_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      mtime_q  <= mtime_d;
      msip_q   <= msip_d;
      rvalid_q <= membus.valid;
      rdata_q  <= rdata_d;
    end
  end

  assign membus.ready  = 1'b1;
  assign membus.rvalid = rvalid_q;
  assign membus.rdata  = rdata_q;
  assign msip          = msip_q;
  assign mtime         = mtime_q;
endmodule

// File: tb/tb_aclint_multi_hart.sv
module tb_aclint_multi_hart;
  localparam int N  = 2;
  localparam int TD = 4;

  logic clk, rst;
  logic [N-1:0] msip, mtip;
  logic [63:0]  mtime;
  int checks = 0, failures = 0;

  aclint_multi_hart_if bus ();

  aclint_multi_hart #(.HART_NUM(N), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .membus(bus), .msip(msip), .mtip(mtip), .mtime(mtime)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural state as plain values.
  longint unsigned m_mtime;
  longint unsigned m_cmp [N];
  bit              m_msip[N];
  bit              m_mtip[N];
  int              m_presc;
  bit              e_rvalid;
  logic [63:0]     e_rdata;

  function automatic logic [63:0] merge(logic [63:0] o, logic [63:0] n, logic [7:0] m);
    logic [63:0] r = o;
    for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, predict, clock, compare.
  task automatic step(input string tag, input bit r, input bit v, input bit w,
                      input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
    int unsigned off;
    longint unsigned nm;
    logic [63:0] rv;
    bit tk;
    bit n_mtip[N];
    rst = r; bus.valid = v; bus.wen = w; bus.addr = a; bus.wdata = d; bus.wmask = m;
    off = 32'(a[15:0]) & 32'hFFF8;
    rv = '0;
    if (v && !w) begin
      if (off < 32'h4000) begin
        if (2*(off/8) < N)   rv[0]  = m_msip[2*(off/8)];
        if (2*(off/8)+1 < N) rv[32] = m_msip[2*(off/8)+1];
      end else if (off >= 32'h4000 && off < 32'h4000 + 8*N)
        rv = m_cmp[(off - 32'h4000)/8];
      else if (off == 32'hBFF8)
        rv = m_mtime;
    end
    for (int h = 0; h < N; h++) n_mtip[h] = (m_mtime >= m_cmp[h]);
`ifdef ACLINT_PRESCALE_EN
    tk = (m_presc == TD-1);
    m_presc = tk ? 0 : m_presc + 1;
`else
    tk = 1'b1;
`endif
    nm = m_mtime + (tk ? 64'd1 : 64'd0);
    if (v && w) begin
      if (off < 32'h4000) begin
        for (int h = 0; h < N; h++)
          if (h/2 == off/8 && m[4*(h%2)]) m_msip[h] = d[32*(h%2)];
      end else if (off >= 32'h4000 && off < 32'h4000 + 8*N)
        m_cmp[(off - 32'h4000)/8] = merge(m_cmp[(off - 32'h4000)/8], d, m);
      else if (off == 32'hBFF8)
        nm = merge(nm, d, m);
    end
    m_mtime  = nm;
    m_mtip   = n_mtip;
    e_rvalid = v;
    e_rdata  = rv;
    if (r) begin
      m_mtime = 0; m_presc = 0; e_rvalid = 0; e_rdata = '0;
      for (int h = 0; h < N; h++) begin m_cmp[h] = '1; m_msip[h] = 0; m_mtip[h] = 0; end
    end
    @(posedge clk); #1;
    chk({tag, ".rvalid"}, 64'(bus.rvalid), 64'(e_rvalid));
    chk({tag, ".rdata"},  bus.rdata, e_rdata);
    chk({tag, ".msip"},   64'(msip), 64'({m_msip[1], m_msip[0]}));
    chk({tag, ".mtip"},   64'(mtip), 64'({m_mtip[1], m_mtip[0]}));
    chk({tag, ".mtime"},  mtime, m_mtime);
    chk({tag, ".ready"},  64'(bus.ready), 64'd1);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 64'h0, 64'h0, 8'h0);
  endtask

  initial begin
    logic [63:0] a, d;
    logic [7:0]  m;
    int sel;
    m_mtime = 0; m_presc = 0;
    for (int h = 0; h < N; h++) begin m_cmp[h] = '1; m_msip[h] = 0; m_mtip[h] = 0; end
    rst = 1; bus.valid = 0; bus.wen = 0; bus.addr = '0; bus.wdata = '0; bus.wmask = '0;

    step("reset0", 1, 0, 0, 64'h0, 64'h0, 8'h0);
    step("reset1", 1, 0, 0, 64'h0, 64'h0, 8'h0);
    idle("post_reset", 2);
    step("rd_cmp0",  0, 1, 0, 64'h4000, 64'h0, 8'h0);
    step("rd_mtime", 0, 1, 0, 64'hBFF8, 64'h0, 8'h0);
    idle("rd_tail", 1);

    step("msip_lo",  0, 1, 1, 64'h0000, 64'h1_0000_0001, 8'h0F);
    step("msip_hi",  0, 1, 1, 64'h0000, 64'h1_0000_0001, 8'hF0);
    step("msip_rd",  0, 1, 0, 64'h0004, 64'h0, 8'h0);
    idle("msip_tail", 1);

    step("wr_cmp1",  0, 1, 1, 64'h4008, 64'd105, 8'hFF);
    step("wr_mtime", 0, 1, 1, 64'hBFF8, 64'd100, 8'hFF);
    idle("mtip_rise", 8 * TD);

    step("wr_wrap",  0, 1, 1, 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    step("wrap_gap", 0, 0, 0, 64'h0, 64'h0, 8'h0);
    step("wrap_rd1", 0, 1, 0, 64'hBFF8, 64'h0, 8'h0);
    step("wrap_rd2", 0, 1, 0, 64'hBFF8, 64'h0, 8'h0);
    idle("wrap_tail", 2);

    step("unm_wr",   0, 1, 1, 64'h8000, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
    step("unm_rd",   0, 1, 0, 64'h8000, 64'h0, 8'h0);
    step("hart2_wr", 0, 1, 1, 64'h0008, 64'h1_0000_0001, 8'hFF);
    step("cmp2_wr",  0, 1, 1, 64'h4010, 64'h0, 8'hFF);
    step("cmp2_rd",  0, 1, 0, 64'h4010, 64'h0, 8'h0);

    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0: a = 64'h0000; 1: a = 64'h0008; 2: a = 64'h4000; 3: a = 64'h4008;
        4: a = 64'h4010; 5: a = 64'hBFF8; 6: a = 64'h8000;
        default: a = {48'h0, 16'($urandom)};
      endcase
      a[63:16] = 48'({$urandom, $urandom});
      a[2:0]   = 3'($urandom);
      d = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) d = m_mtime + 64'($urandom_range(0, 30));
      m = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
      step("rand", ($urandom_range(0, 63) == 0), $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1, a, d, m);
    end

    step("pre_rst_wr", 0, 1, 1, 64'h0000, 64'h1_0000_0001, 8'hFF);
    step("rst_in_req", 1, 1, 0, 64'h4000, 64'h0, 8'h0);
    idle("after_rst", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aclint_multi_hart.md
# aclint_multi_hart

Parametrised ACLINT block providing the machine software-interrupt (MSWI) and machine timer (MTIMER) devices for up to eight harts behind one memory-bus slave port. It sits on the core's peripheral bus, holds MTIME, one MTIMECMP per hart and one MSIP bit per hart, and drives per-hart `msip`/`mtip` interrupt lines plus the current `mtime` value to the CSR unit.

## Interface
- `HART_NUM`, 1: number of harts, legal range 1..8.
- `TICK_DIV`, 1: clock cycles per MTIME increment, ≥1; used only with `ACLINT_PRESCALE_EN`.
- `clk` in 1: the only clock.
- `rst` in 1: reset, synchronous and active-high.
- `membus_valid` in 1: request valid.
- `membus_ready` out 1: request accepted; tied to 1.
- `membus_addr` in 64: byte address; only bits [15:0] are decoded.
- `membus_wen` in 1: 1 = write, 0 = read.
- `membus_wdata` in 64: write data.
- `membus_wmask` in 8: byte-lane write enables.
- `membus_rvalid` out 1: response valid for both reads and writes.
- `membus_rdata` out 64: read data.
- `msip` out HART_NUM: per-hart software interrupt pending.
- `mtip` out HART_NUM: per-hart timer interrupt pending.
- `mtime` out 64: current MTIME register.

## Operation
- Access unit: 64-bit word at `addr[15:3]`; `addr[2:0]` ignored; byte lanes are selected by `wmask`.
- MSIP region, 0x0000–0x3FFF: the word at 0x0000+8k holds MSIP[2k] in bit 0 (lane 0) and MSIP[2k+1] in bit 32 (lane 4). All other bits read 0. Harts ≥ HART_NUM read 0 and ignore writes.
- MTIMECMP region, 0x4000+8h: 64-bit, byte-maskable, for h < HART_NUM.
- MTIME, 0xBFF8: 64-bit, byte-maskable, read/write.
- Unmapped addresses: reads return 0; writes are dropped. Every request still gets `rvalid`.
- MTIME increments by 1 per tick and wraps from 2^64−1 to 0. A write to MTIME in a cycle overrides that cycle's increment for the written bytes; the unwritten bytes take the incremented value.
- `mtip[h]` is driven from a register loaded each cycle with (MTIME ≥ MTIMECMP[h]), unsigned 64-bit compare of current register values.
- Reset values: MTIME 0, MTIMECMP all 0xFFFF_FFFF_FFFF_FFFF, MSIP 0, `msip` 0, `mtip` 0, `membus_rvalid` 0, `membus_rdata` 0, prescaler 0.

## Timing
- `membus_ready` is always 1; one request is accepted per cycle; there is no backpressure.
- `rvalid` asserts exactly 1 cycle after an accepted request and lasts 1 cycle. Back-to-back requests give back-to-back `rvalid`.
- `rdata` is registered and holds the register value sampled in the request cycle, before that cycle's update. For writes, `rdata` is 0.
- Write takes effect on the clock edge ending the request cycle. A read in the following cycle returns the new value.
- `msip` changes in the cycle after the write.
- `mtip` asserts/deasserts 1 cycle after the compare condition changes in the registers. A MTIMECMP write lowers `mtip` 2 cycles after the write request.
- `rst` asserted mid-transaction cancels any pending `rvalid` in the next cycle, and all state returns to reset values.

## Configuration
- `ACLINT_PRESCALE_EN` defined: a prescaler counts 0..TICK_DIV−1. MTIME increments in the cycle the prescaler wraps. An MTIME write does not reset the prescaler.
- Not defined: MTIME increments every cycle, `TICK_DIV` is ignored, and no prescaler register exists.

## Test plan
- Reset, then read 0x4000 and 0xBFF8 → `rvalid` 1 cycle later; rdata 0xFFFF_FFFF_FFFF_FFFF and a small MTIME value; `mtip` = 0.
- HART_NUM=2: write 0x0000 wdata 0x1_0000_0001, wmask 0x0F → `msip` = 2'b01; then wmask 0xF0 → `msip` = 2'b11; read returns 0x0000_0001_0000_0001.
- Write MTIME = 100 and MTIMECMP[1] (0x4008) = 105, prescale off → `mtip[1]` rises 6 cycles after the MTIME write; `mtip[0]` stays 0.
- Write MTIME = 0xFFFF_FFFF_FFFF_FFFE → reads 2 and 3 cycles later return 0xFFFF_FFFF_FFFF_FFFF and 0.
- With ACLINT_PRESCALE_EN, TICK_DIV=4 → MTIME advances by 1 every 4 cycles. Reads at unmapped 0x8000 → 0; writes there change nothing.
- Assert `rst` in a request cycle → no `rvalid`, and all outputs are at reset values the next cycle.
